// File: rtl/pipif_prefetch_rv32.sv
// RV32 instruction-fetch stage: credit-limited request issue, in-order response
// capture into a {pc, instr} prefetch FIFO, and branch redirect with stale-response drop.
module pipif_prefetch_rv32 #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned DEPTH        = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  output logic        oIREQ,
  output logic [31:0] oIADDR,
  input  logic        iIACK,
  input  logic        iIVALID,
  input  logic [31:0] iIDATA,
  input  logic        iBRANCH,
  input  logic [31:0] iBranchADDR,
  input  logic        iStallD,
  output logic        oVALID,
  output logic [31:0] oINSTR,
  output logic [31:0] oPC
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_W  = (CW+1)'(DEPTH);
  localparam logic [31:0] RESET_PC = RESET_VECTOR & ~32'h3;

  logic [31:0]   fetchPc;
  logic [31:0]   respPc;
  logic [31:0]   fifoPc    [DEPTH];
  logic [31:0]   fifoInstr [DEPTH];
  logic [AW-1:0] rdPtr;
  logic [AW-1:0] wrPtr;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] discard;
  logic [31:0]   branchPc;
  logic          transfer;
  logic          respTake;
  logic          push;
  logic          pop;

  // Every buffered word and every outstanding request holds one of DEPTH credits.
  assign oIREQ    = !iRST && !iBRANCH && (({1'b0, count} + {1'b0, inflight}) < DEPTH_W);
  assign oIADDR   = fetchPc;
  assign oVALID   = !iRST && (count != '0);
  assign oINSTR   = fifoInstr[rdPtr];
  assign oPC      = fifoPc[rdPtr];

  assign branchPc = iBranchADDR & ~32'h3;
  assign transfer = oIREQ && iIACK;
  assign respTake = iIVALID && (inflight != '0);
  assign push     = respTake && (discard == '0);
  assign pop      = oVALID && !iStallD;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      fetchPc  <= RESET_PC;
      respPc   <= RESET_PC;
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
    end else if (iBRANCH) begin
      // Everything still outstanding belongs to the old stream; a response landing now is dropped too.
      fetchPc  <= branchPc;
      respPc   <= branchPc;
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      inflight <= inflight - CW'(respTake);
      discard  <= inflight - CW'(respTake);
    end else begin
      if (transfer) fetchPc <= fetchPc + 32'd4;
      if (respTake && (discard != '0)) discard <= discard - CW'(1);
      if (push) begin
        wrPtr  <= wrPtr + AW'(1);
        respPc <= respPc + 32'd4;
      end
      if (pop) rdPtr <= rdPtr + AW'(1);
      count    <= count + CW'(push) - CW'(pop);
      inflight <= inflight + CW'(transfer) - CW'(respTake);
    end
  end

  // Payload storage needs no reset; oVALID masks it.
  always_ff @(posedge iCLK) begin
    if (!iRST && !iBRANCH && push) begin
      fifoPc[wrPtr]    <= respPc;
      fifoInstr[wrPtr] <= iIDATA;
    end
  end
endmodule
